// File: rtl/nco_tuning_controller.sv
// nco_tuning_controller
// Sequences frequency tuning word updates into an NCO phase accumulator.
// A configuration either jumps straight to its target FTW or ramps toward
// it in fixed-size steps, with a programmable dwell between steps.
// Optional feature macro: NCO_CTRL_STEP_COUNT_EN adds a saturating
// step_cnt output that counts applied sweep steps.

module nco_tuning_controller #(
    parameter int N       = 32,
    parameter int STEP_W  = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [N-1:0]       cfg_ftw,
    input  logic [STEP_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_phase_clr,
    input  logic               abort,
    output logic [N-1:0]       ftw_out,
    output logic               acc_clr,
    output logic               busy,
`ifdef NCO_CTRL_STEP_COUNT_EN
    output logic               done,
    output logic [15:0]        step_cnt
`else
    output logic               done
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state;
    logic [N-1:0]       target;
    logic [N-1:0]       step_mag;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dir_up;

    logic               accept;
    logic               jump;
    logic [N-1:0]       distance;
    logic               last_step;
    logic [N-1:0]       stepped_ftw;

    // Decode the handshake and precompute the next sweep step and whether it lands on the target
    always_comb begin
        accept      = 1'b0;
        jump        = 1'b0;
        distance    = '0;
        last_step   = 1'b0;
        stepped_ftw = ftw_out;
        accept      = cfg_valid && cfg_ready && (state == IDLE);
        jump        = (cfg_step == '0) || (cfg_ftw == ftw_out);
        if (dir_up) begin
            distance    = target - ftw_out;
            stepped_ftw = ftw_out + step_mag;
        end else begin
            distance    = ftw_out - target;
            stepped_ftw = ftw_out - step_mag;
        end
        last_step   = (distance <= step_mag);
    end

    // Main control FSM: accept configurations, pace sweep steps by the dwell counter, handle abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ftw_out   <= '0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b0;
            target    <= '0;
            step_mag  <= '0;
            dwell     <= '0;
            dwell_cnt <= '0;
            dir_up    <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    if (accept) begin
                        target   <= cfg_ftw;
                        step_mag <= {{(N-STEP_W){1'b0}}, cfg_step};
                        dwell    <= cfg_dwell;
                        dir_up   <= (cfg_ftw > ftw_out);
                        acc_clr  <= cfg_phase_clr;
                        if (jump) begin
                            ftw_out <= cfg_ftw;
                            done    <= 1'b1;
                        end else begin
                            state     <= SWEEP;
                            busy      <= 1'b1;
                            cfg_ready <= 1'b0;
                            dwell_cnt <= cfg_dwell;
                        end
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else begin
                        dwell_cnt <= dwell;
                        if (last_step) begin
                            ftw_out   <= target;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            ftw_out <= stepped_ftw;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef NCO_CTRL_STEP_COUNT_EN
    logic step_applied;

    // A step is applied whenever the sweep runs out its dwell without being aborted
    always_comb begin
        step_applied = 1'b0;
        step_applied = (state == SWEEP) && !abort && (dwell_cnt == '0);
    end

    // Count applied sweep steps per configuration, saturating at the top of the range
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else if (accept) begin
            step_cnt <= '0;
        end else if (step_applied && (step_cnt != 16'hFFFF)) begin
            step_cnt <= step_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nco_tuning_controller.sv
// Directed testbench for nco_tuning_controller with hand-computed expectations.

module tb_nco_tuning_controller;

    logic        clk;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_ftw;
    logic [15:0] cfg_step;
    logic [15:0] cfg_dwell;
    logic        cfg_phase_clr;
    logic        abort;
    logic [31:0] ftw_out;
    logic        acc_clr;
    logic        busy;
    logic        done;
`ifdef NCO_CTRL_STEP_COUNT_EN
    logic [15:0] step_cnt;
`endif

    int checks = 0;
    int errors = 0;

    nco_tuning_controller #(.N(32), .STEP_W(16), .DWELL_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ftw       (cfg_ftw),
        .cfg_step      (cfg_step),
        .cfg_dwell     (cfg_dwell),
        .cfg_phase_clr (cfg_phase_clr),
        .abort         (abort),
        .ftw_out       (ftw_out),
        .acc_clr       (acc_clr),
        .busy          (busy),
`ifdef NCO_CTRL_STEP_COUNT_EN
        .done          (done),
        .step_cnt      (step_cnt)
`else
        .done          (done)
`endif
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare an observed value with the expected one and count the result
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a configuration on the input bus
    task automatic applyStimulus(input logic valid, input logic [31:0] ftw, input logic [15:0] step,
                                 input logic [15:0] dwell, input logic clr);
        cfg_valid     = valid;
        cfg_ftw       = ftw;
        cfg_step      = step;
        cfg_dwell     = dwell;
        cfg_phase_clr = clr;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        abort = 1'b0;
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        #12;
        checkOutput("rst_ftw", ftw_out, 32'h0);
        checkOutput("rst_ready", {31'b0, cfg_ready}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_done", {31'b0, done}, 32'h0);
        checkOutput("rst_accclr", {31'b0, acc_clr}, 32'h0);
        #6 reset = 1'b1;
        tick();
        checkOutput("ready_after_rst", {31'b0, cfg_ready}, 32'h1);

        // Immediate jump with phase clear
        applyStimulus(1'b1, 32'h0000_1000, 16'h0, 16'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        checkOutput("jump_ftw", ftw_out, 32'h1000);
        checkOutput("jump_accclr", {31'b0, acc_clr}, 32'h1);
        checkOutput("jump_done", {31'b0, done}, 32'h1);
        checkOutput("jump_busy", {31'b0, busy}, 32'h0);
        tick();
        checkOutput("jump_accclr_off", {31'b0, acc_clr}, 32'h0);
        checkOutput("jump_done_off", {31'b0, done}, 32'h0);

        // Up sweep with dwell 2, second configuration held during the sweep
        applyStimulus(1'b1, 32'h0000_1010, 16'd4, 16'd2, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000_1010, 16'd7, 16'd0, 1'b0);
        checkOutput("up_busy_k", {31'b0, busy}, 32'h1);
        checkOutput("up_ready_k", {31'b0, cfg_ready}, 32'h0);
        checkOutput("up_ftw_k", ftw_out, 32'h1000);
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkOutput($sformatf("up_ftw_%0d", i), ftw_out, 32'h1000 + 32'(4 * (i / 3)));
            checkOutput($sformatf("up_busy_%0d", i), {31'b0, busy}, (i < 12) ? 32'h1 : 32'h0);
            checkOutput($sformatf("up_done_%0d", i), {31'b0, done}, (i == 12) ? 32'h1 : 32'h0);
            checkOutput($sformatf("up_ready_%0d", i), {31'b0, cfg_ready}, (i == 12) ? 32'h1 : 32'h0);
        end
`ifdef NCO_CTRL_STEP_COUNT_EN
        checkOutput("up_stepcnt", {16'b0, step_cnt}, 32'd4);
`endif
        // Held configuration targets the current FTW, so it is taken as a jump
        tick();
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        checkOutput("held_done", {31'b0, done}, 32'h1);
        checkOutput("held_busy", {31'b0, busy}, 32'h0);
        checkOutput("held_ftw", ftw_out, 32'h1010);

        // Down sweep with clamped final step
        applyStimulus(1'b1, 32'h0000_1005, 16'd4, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        checkOutput("dn_busy", {31'b0, busy}, 32'h1);
        checkOutput("dn_ftw0", ftw_out, 32'h1010);
        tick();
        checkOutput("dn_ftw1", ftw_out, 32'h100C);
        tick();
        checkOutput("dn_ftw2", ftw_out, 32'h1008);
        checkOutput("dn_done2", {31'b0, done}, 32'h0);
        tick();
        checkOutput("dn_ftw3", ftw_out, 32'h1005);
        checkOutput("dn_done3", {31'b0, done}, 32'h1);
        checkOutput("dn_busy3", {31'b0, busy}, 32'h0);

        // Jump back to zero, then sweep up and abort after ten steps
        applyStimulus(1'b1, 32'h0, 16'h0, 16'h0, 1'b0);
        tick();
        checkOutput("zero_ftw", ftw_out, 32'h0);
        applyStimulus(1'b1, 32'h0000_0100, 16'd1, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("ab_ftw_pre", ftw_out, 32'h0A);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("ab_ftw", ftw_out, 32'h0A);
        checkOutput("ab_busy", {31'b0, busy}, 32'h0);
        checkOutput("ab_done", {31'b0, done}, 32'h0);
        checkOutput("ab_ready", {31'b0, cfg_ready}, 32'h1);

        // Abort in IDLE is ignored; configuration is accepted and sweeps with dwell 1
        abort = 1'b1;
        applyStimulus(1'b1, 32'h0000_0020, 16'h10, 16'd1, 1'b0);
        tick();
        abort = 1'b0;
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        checkOutput("idle_abort_busy", {31'b0, busy}, 32'h1);
        tick();
        checkOutput("dw1_ftw1", ftw_out, 32'h0A);
        tick();
        checkOutput("dw1_ftw2", ftw_out, 32'h1A);
        tick();
        tick();
        checkOutput("dw1_ftw4", ftw_out, 32'h20);
        checkOutput("dw1_done4", {31'b0, done}, 32'h1);

        // Asynchronous reset in the middle of a sweep
        applyStimulus(1'b1, 32'h0000_0100, 16'd1, 16'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        checkOutput("pre_rst_ftw", ftw_out, 32'h22);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_ftw", ftw_out, 32'h0);
        checkOutput("async_busy", {31'b0, busy}, 32'h0);
        checkOutput("async_ready", {31'b0, cfg_ready}, 32'h0);
        #10 reset = 1'b1;
        tick();
        checkOutput("async_ready_back", {31'b0, cfg_ready}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
